// File: rtl/gpu_pkg.sv
// Shared definitions for the pixel-plane path: screen geometry, pixel
// format widths and the rectangle-fill engine state encoding.
package gpu_pkg;

    localparam int H_RES      = 320;
    localparam int V_RES      = 240;
    localparam int PIX_ADDR_W = 17;
    localparam int PIX_W      = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        FILL  = 2'd2,
        DONE  = 2'd3
    } fill_state_e;

    // Exclusive end coordinate clamped to the visible limit; 10 bits wide so
    // origin + size never wraps.
    function automatic logic [9:0] clip_end(input logic [9:0] start_plus_len,
                                            input logic [9:0] limit);
        return (start_plus_len > limit) ? limit : start_plus_len;
    endfunction

endpackage

// File: rtl/pixel_fill_engine.sv
// Rectangle-fill writer for the 320x240 RGB888 pixel plane. Accepts one
// command, clips it to the screen and streams the colour into the VRAM
// write port one pixel per clock, row-major, with no bubbles at row ends.
module pixel_fill_engine
    import gpu_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [8:0]            cmd_x,
    input  logic [7:0]            cmd_y,
    input  logic [8:0]            cmd_w,
    input  logic [7:0]            cmd_h,
    input  logic [PIX_W-1:0]      cmd_color,
    output logic [PIX_ADDR_W-1:0] vram_addr,
    output logic [PIX_W-1:0]      vram_d,
    output logic                  vram_we,
    output logic                  busy,
    output logic                  done
);

    fill_state_e            state_q, state_d;
    logic [8:0]             x_q, x_d;
    logic [7:0]             y_q, y_d;
    logic [8:0]             w_q, w_d;
    logic [7:0]             h_q, h_d;
    logic [PIX_W-1:0]       color_q, color_d;
    logic [9:0]             x_end_q, x_end_d;
    logic [9:0]             y_end_q, y_end_d;
    logic [8:0]             cur_x_q, cur_x_d;
    logic [7:0]             cur_y_q, cur_y_d;
    logic [PIX_ADDR_W-1:0]  row_base_q, row_base_d;
    // The write address counter doubles as the vram_addr output register.
    logic [PIX_ADDR_W-1:0]  addr_q, addr_d;
    logic [PIX_W-1:0]       vram_d_q, vram_d_d;
    logic                   vram_we_q, vram_we_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   cmd_ready_q, cmd_ready_d;

    // y*320 built from shifts: (y<<8) + (y<<6).
    logic [PIX_ADDR_W-1:0]  setup_row_base;
    logic                   setup_empty;

    assign setup_row_base = {1'b0, y_q, 8'd0} + {3'd0, y_q, 6'd0};
    assign setup_empty    = (x_q >= 9'(H_RES)) || (y_q >= 8'(V_RES)) ||
                            (w_q == 9'd0) || (h_q == 8'd0);

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        w_d         = w_q;
        h_d         = h_q;
        color_d     = color_q;
        x_end_d     = x_end_q;
        y_end_d     = y_end_q;
        cur_x_d     = cur_x_q;
        cur_y_d     = cur_y_q;
        row_base_d  = row_base_q;
        addr_d      = addr_q;
        vram_d_d    = vram_d_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    x_d     = cmd_x;
                    y_d     = cmd_y;
                    w_d     = cmd_w;
                    h_d     = cmd_h;
                    color_d = cmd_color;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                x_end_d    = clip_end({1'b0, x_q} + {1'b0, w_q}, 10'(H_RES));
                y_end_d    = clip_end({2'b0, y_q} + {2'b0, h_q}, 10'(V_RES));
                row_base_d = setup_row_base;
                if (setup_empty) begin
                    state_d = DONE;
                end else begin
                    cur_x_d  = x_q;
                    cur_y_d  = y_q;
                    addr_d   = setup_row_base + {8'd0, x_q};
                    vram_d_d = color_q;
                    state_d  = FILL;
                end
            end
            FILL: begin
                if ({1'b0, cur_x_q} + 10'd1 < x_end_q) begin
                    cur_x_d = cur_x_q + 9'd1;
                    addr_d  = addr_q + 17'd1;
                end else if ({2'b0, cur_y_q} + 10'd1 < y_end_q) begin
                    // Row wrap computed from the old base so the next
                    // address is ready without a bubble.
                    cur_x_d    = x_q;
                    cur_y_d    = cur_y_q + 8'd1;
                    row_base_d = row_base_q + 17'(H_RES);
                    addr_d     = row_base_q + 17'(H_RES) + {8'd0, x_q};
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        vram_we_d   = (state_d == FILL);
        done_d      = (state_d == DONE);
        busy_d      = (state_d != IDLE);
        cmd_ready_d = (state_d == IDLE);
    end

    // State, command and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            w_q         <= '0;
            h_q         <= '0;
            color_q     <= '0;
            x_end_q     <= '0;
            y_end_q     <= '0;
            cur_x_q     <= '0;
            cur_y_q     <= '0;
            row_base_q  <= '0;
            addr_q      <= '0;
            vram_d_q    <= '0;
            vram_we_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            w_q         <= w_d;
            h_q         <= h_d;
            color_q     <= color_d;
            x_end_q     <= x_end_d;
            y_end_q     <= y_end_d;
            cur_x_q     <= cur_x_d;
            cur_y_q     <= cur_y_d;
            row_base_q  <= row_base_d;
            addr_q      <= addr_d;
            vram_d_q    <= vram_d_d;
            vram_we_q   <= vram_we_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign vram_addr = addr_q;
    assign vram_d    = vram_d_q;
    assign vram_we   = vram_we_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_pixel_fill_engine.sv
// Directed plus randomized bench for pixel_fill_engine. Expected writes come
// from clipping each rectangle with plain integer arithmetic and walking it
// row-major; every cycle of every command is checked against that walk.
module tb_pixel_fill_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [8:0]  cmd_x;
    logic [7:0]  cmd_y;
    logic [8:0]  cmd_w;
    logic [7:0]  cmd_h;
    logic [23:0] cmd_color;
    logic [16:0] vram_addr;
    logic [23:0] vram_d;
    logic        vram_we;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    pixel_fill_engine dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .cmd_w     (cmd_w),
        .cmd_h     (cmd_h),
        .cmd_color (cmd_color),
        .vram_addr (vram_addr),
        .vram_d    (vram_d),
        .vram_we   (vram_we),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one command and check every cycle up to the return to idle.
    // With hold set, cmd_valid stays high and the fields are scrambled while
    // the engine is busy; the caller then presents the follow-up command.
    task automatic run_cmd(input int x, input int y, input int w, input int h,
                           input logic [23:0] c, input bit hold);
        int xe, ye, n, wait_cycles, writes;
        cmd_x     = 9'(x);
        cmd_y     = 8'(y);
        cmd_w     = 9'(w);
        cmd_h     = 8'(h);
        cmd_color = c;
        cmd_valid = 1'b1;
        wait_cycles = 0;
        while (cmd_ready !== 1'b1 && wait_cycles < 10) begin
            step();
            wait_cycles++;
        end
        check("ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
        step();  // handshake edge T; now in cycle T+1 (setup)
        if (!hold) cmd_valid = 1'b0;

        xe = (x + w > 320) ? 320 : x + w;
        ye = (y + h > 240) ? 240 : y + h;
        writes = 0;
        if (x < 320 && y < 240) writes = (xe - x) * (ye - y);
        $display("cmd x=%0d y=%0d w=%0d h=%0d color=%06h expected_writes=%0d",
                 x, y, w, h, c, writes);

        check("setup_we", {31'd0, vram_we}, 32'd0);
        check("setup_busy", {31'd0, busy}, 32'd1);
        check("setup_ready", {31'd0, cmd_ready}, 32'd0);

        n = 0;
        for (int yy = y; yy < ye; yy++) begin
            for (int xx = x; xx < xe; xx++) begin
                step();
                if (hold) begin
                    cmd_x     = 9'($urandom);
                    cmd_y     = 8'($urandom);
                    cmd_w     = 9'($urandom);
                    cmd_h     = 8'($urandom);
                    cmd_color = 24'($urandom);
                end
                check("write_we", {31'd0, vram_we}, 32'd1);
                check("write_addr", {15'd0, vram_addr}, 32'(yy * 320 + xx));
                check("write_data", {8'd0, vram_d}, {8'd0, c});
                check("write_ready", {31'd0, cmd_ready}, 32'd0);
                n++;
            end
        end

        step();  // done cycle
        check("done_pulse", {31'd0, done}, 32'd1);
        check("done_we", {31'd0, vram_we}, 32'd0);
        check("done_busy", {31'd0, busy}, 32'd1);
        check("done_ready", {31'd0, cmd_ready}, 32'd0);

        step();  // back in idle
        check("idle_ready", {31'd0, cmd_ready}, 32'd1);
        check("idle_done", {31'd0, done}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_we", {31'd0, vram_we}, 32'd0);
    endtask

    initial begin
        int n;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_x     = '0;
        cmd_y     = '0;
        cmd_w     = '0;
        cmd_h     = '0;
        cmd_color = '0;
        step();
        step();
        reset = 1'b0;
        check("rst_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_we", {31'd0, vram_we}, 32'd0);
        check("rst_addr", {15'd0, vram_addr}, 32'd0);
        check("rst_data", {8'd0, vram_d}, 32'd0);

        // Basic 2x2 rectangle.
        run_cmd(1, 1, 2, 2, 24'hFF8000, 1'b0);
        // Clipped at the bottom-right corner.
        run_cmd(318, 238, 10, 10, 24'h123456, 1'b0);
        // Degenerate and fully clipped commands.
        run_cmd(5, 5, 0, 5, 24'hAAAAAA, 1'b0);
        run_cmd(5, 5, 5, 0, 24'hBBBBBB, 1'b0);
        run_cmd(320, 5, 5, 5, 24'hCCCCCC, 1'b0);
        run_cmd(5, 240, 5, 5, 24'hDDDDDD, 1'b0);
        // Single pixel at the last address, and one full row.
        run_cmd(319, 239, 1, 1, 24'h00FF00, 1'b0);
        run_cmd(0, 7, 320, 1, 24'h0000FF, 1'b0);

        // Reset in the middle of a fill after 50 writes.
        cmd_x = 9'd0; cmd_y = 8'd0; cmd_w = 9'd100; cmd_h = 8'd100;
        cmd_color = 24'h5A5A5A;
        cmd_valid = 1'b1;
        step();  // handshake happened at this edge (engine was idle)
        cmd_valid = 1'b0;
        check("mid_setup_we", {31'd0, vram_we}, 32'd0);
        for (int i = 0; i < 50; i++) begin
            step();
            check("mid_write_addr", {15'd0, vram_addr}, 32'(i));
            check("mid_write_we", {31'd0, vram_we}, 32'd1);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_we", {31'd0, vram_we}, 32'd0);
        check("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("mid_no_done", {31'd0, done}, 32'd0);
            check("mid_no_we", {31'd0, vram_we}, 32'd0);
        end
        run_cmd(10, 20, 3, 2, 24'h0F0F0F, 1'b0);

        // Held cmd_valid with changing fields while busy.
        run_cmd(100, 100, 3, 2, 24'hFEDCBA, 1'b1);
        run_cmd(200, 50, 2, 3, 24'h13579B, 1'b0);

        // Randomized commands, biased toward the clipping edges.
        for (int k = 0; k < 20; k++) begin
            run_cmd(int'($urandom_range(0, 340)), int'($urandom_range(0, 250)),
                    int'($urandom_range(0, 20)), int'($urandom_range(0, 20)),
                    24'($urandom), 1'b0);
        end

        // Full screen.
        run_cmd(0, 0, 320, 240, 24'h808080, 1'b0);

        n = failures;
        $display("TB_RESULT checks=%0d failures=%0d", checks, n);
        $finish;
    end

endmodule
